// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: groups the CPU, DMA and DRAM-controller signals of the
// DRAM arbiter into one bundle.
//   CPU side : CPU_AS/CS/RW/UDS/LDS/ADDR in, CPU_DTACK out (68000 style, active-low)
//   DMA side : DMA_REQ/RW/BE/ADDR in, DMA_GNT/DMA_DONE out
//   MEM side : MEM_REQ/RW/UDS/LDS/ADDR, MEM_REF_REQ out; MEM_ACK, MEM_REF_ACK in
//   status   : REF_OVERRUN out
// modport master is the arbiter itself; slave is everything around it.
interface dram_arbiter_if;
  logic        CPU_AS;
  logic        CPU_CS;
  logic        CPU_RW;
  logic        CPU_UDS;
  logic        CPU_LDS;
  logic [22:0] CPU_ADDR;
  logic        CPU_DTACK;

  logic        DMA_REQ;
  logic        DMA_RW;
  logic [1:0]  DMA_BE;
  logic [22:0] DMA_ADDR;
  logic        DMA_GNT;
  logic        DMA_DONE;

  logic        MEM_REQ;
  logic        MEM_RW;
  logic        MEM_UDS;
  logic        MEM_LDS;
  logic [22:0] MEM_ADDR;
  logic        MEM_ACK;
  logic        MEM_REF_REQ;
  logic        MEM_REF_ACK;

  logic        REF_OVERRUN;

  modport master (
    input  CPU_AS, CPU_CS, CPU_RW, CPU_UDS, CPU_LDS, CPU_ADDR,
    output CPU_DTACK,
    input  DMA_REQ, DMA_RW, DMA_BE, DMA_ADDR,
    output DMA_GNT, DMA_DONE,
    output MEM_REQ, MEM_RW, MEM_UDS, MEM_LDS, MEM_ADDR, MEM_REF_REQ,
    input  MEM_ACK, MEM_REF_ACK,
    output REF_OVERRUN
  );

  modport slave (
    output CPU_AS, CPU_CS, CPU_RW, CPU_UDS, CPU_LDS, CPU_ADDR,
    input  CPU_DTACK,
    output DMA_REQ, DMA_RW, DMA_BE, DMA_ADDR,
    input  DMA_GNT, DMA_DONE,
    input  MEM_REQ, MEM_RW, MEM_UDS, MEM_LDS, MEM_ADDR, MEM_REF_REQ,
    output MEM_ACK, MEM_REF_ACK,
    input  REF_OVERRUN
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: chooses the next DRAM controller operation among CPU access,
// DMA access and refresh, and owns the refresh schedule.
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : dram_arbiter_if.master (CPU, DMA, MEM and status signals)
// Priority in IDLE: urgent refresh > CPU/DMA round-robin > idle-time refresh.
module dram_arbiter #(
  parameter int REFRESH_INTERVAL = 150,  // CLK cycles per refresh tick (2..256)
  parameter int MAX_PENDING      = 2     // pending count that forces refresh (1..7)
) (
  input logic          CLK,
  input logic          RST,
  dram_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_END, DMA_ACC, REF} state_t;

  state_t     state;
  logic [7:0] tick_cnt;
  logic [2:0] pending;
  logic       last_dma;   // 1: DMA was served last, so CPU wins a tie
  logic       tick;
  logic       cpu_req, dma_req, urgent;
  logic       ref_gnt, cpu_gnt, dma_gnt;

  assign tick = (tick_cnt == 8'(REFRESH_INTERVAL - 1));

  always_comb begin
    cpu_req = ~bus.CPU_CS & ~bus.CPU_AS;
    dma_req = bus.DMA_REQ;
    urgent  = (pending >= 3'(MAX_PENDING));
    ref_gnt = 1'b0;
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (state == IDLE) begin
      if (urgent)                    ref_gnt = 1'b1;
      else if (cpu_req && dma_req)   begin cpu_gnt = last_dma; dma_gnt = ~last_dma; end
      else if (cpu_req)              cpu_gnt = 1'b1;
      else if (dma_req)              dma_gnt = 1'b1;
      else if (pending != 3'd0)      ref_gnt = 1'b1;
    end
  end

  // Refresh scheduler: pending counts ticks not yet granted, saturating at 7.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_cnt        <= '0;
      pending         <= '0;
      bus.REF_OVERRUN <= 1'b0;
    end else begin
      tick_cnt <= tick ? 8'd0 : tick_cnt + 8'd1;
      case ({tick, ref_gnt})
        2'b10:   if (pending != 3'd7) pending <= pending + 3'd1;
        2'b01:   pending <= pending - 3'd1;
        default: ;
      endcase
      // A tick is only lost when it cannot be counted and no grant offsets it.
      if (tick && !ref_gnt && pending == 3'd7) bus.REF_OVERRUN <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      last_dma        <= 1'b1;
      bus.CPU_DTACK   <= 1'b1;
      bus.DMA_GNT     <= 1'b0;
      bus.DMA_DONE    <= 1'b0;
      bus.MEM_REQ     <= 1'b0;
      bus.MEM_REF_REQ <= 1'b0;
      bus.MEM_RW      <= 1'b1;
      bus.MEM_UDS     <= 1'b1;
      bus.MEM_LDS     <= 1'b1;
      bus.MEM_ADDR    <= '0;
    end else begin
      bus.DMA_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_gnt) begin
            bus.MEM_REF_REQ <= 1'b1;
            state           <= REF;
          end else if (cpu_gnt) begin
            bus.MEM_REQ  <= 1'b1;
            bus.MEM_ADDR <= bus.CPU_ADDR;
            bus.MEM_RW   <= bus.CPU_RW;
            bus.MEM_UDS  <= bus.CPU_UDS;
            bus.MEM_LDS  <= bus.CPU_LDS;
            last_dma     <= 1'b0;
            state        <= CPU_ACC;
          end else if (dma_gnt) begin
            bus.MEM_REQ  <= 1'b1;
            bus.MEM_ADDR <= bus.DMA_ADDR;
            bus.MEM_RW   <= bus.DMA_RW;
            bus.MEM_UDS  <= ~bus.DMA_BE[1];
            bus.MEM_LDS  <= ~bus.DMA_BE[0];
            bus.DMA_GNT  <= 1'b1;
            last_dma     <= 1'b1;
            state        <= DMA_ACC;
          end
        end
        CPU_ACC: begin
          if (bus.MEM_ACK) begin
            bus.MEM_REQ <= 1'b0;
            // A CPU that already ended its bus cycle gets no DTACK.
            if (!bus.CPU_AS) begin
              bus.CPU_DTACK <= 1'b0;
              state         <= CPU_END;
            end else begin
              state <= IDLE;
            end
          end
        end
        CPU_END: begin
          // Wait for AS to rise so the same bus cycle is not granted twice.
          if (bus.CPU_AS) begin
            bus.CPU_DTACK <= 1'b1;
            state         <= IDLE;
          end
        end
        DMA_ACC: begin
          if (bus.MEM_ACK) begin
            bus.MEM_REQ  <= 1'b0;
            bus.DMA_GNT  <= 1'b0;
            bus.DMA_DONE <= 1'b1;
            state        <= IDLE;
          end
        end
        REF: begin
          if (bus.MEM_REF_ACK) begin
            bus.MEM_REF_REQ <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed bench for dram_arbiter. Expected MEM transfers are
// queued when a request is driven and popped when MEM_REQ is observed.
module tb_dram_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  dram_arbiter_if bus();

  dram_arbiter #(.REFRESH_INTERVAL(150), .MAX_PENDING(2)) u_dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [22:0] addr;
    logic        rw;
    logic        uds;
    logic        lds;
  } mem_exp_t;

  mem_exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;       // rising edges since the last reset release
  int done_cnt = 0;  // DMA_DONE cycles observed

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc++;
      done_cnt += int'(bus.DMA_DONE);
    end
  endtask

  // Pop the next expected transfer and compare it with the MEM bus.
  task automatic sb_check(input string tag);
    mem_exp_t e;
    chk({tag, "_req"}, 32'(bus.MEM_REQ), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_xfer"}, 32'({bus.MEM_ADDR, bus.MEM_RW, bus.MEM_UDS, bus.MEM_LDS}), 32'(e));
    end
  endtask

  task automatic mem_ack();
    bus.MEM_ACK = 1'b1;
    step(1);
    bus.MEM_ACK = 1'b0;
  endtask

  task automatic ref_ack();
    bus.MEM_REF_ACK = 1'b1;
    step(1);
    bus.MEM_REF_ACK = 1'b0;
  endtask

  task automatic cpu_start(input logic [22:0] a, input logic rw, input logic u, input logic l);
    bus.CPU_ADDR = a; bus.CPU_RW = rw; bus.CPU_UDS = u; bus.CPU_LDS = l;
    bus.CPU_CS = 1'b0; bus.CPU_AS = 1'b0;
    sb_q.push_back('{addr: a, rw: rw, uds: u, lds: l});
  endtask

  task automatic cpu_end();
    bus.CPU_AS = 1'b1; bus.CPU_CS = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.MEM_ACK = 1'b0; bus.MEM_REF_ACK = 1'b0;
    cpu_end(); bus.DMA_REQ = 1'b0;
    sb_q.delete();
    step(2);
    RST = 1'b0;
    cyc = 0;
    done_cnt = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, 32'({bus.CPU_DTACK, bus.DMA_GNT, bus.DMA_DONE, bus.MEM_REQ, bus.MEM_REF_REQ,
                            bus.MEM_RW, bus.MEM_UDS, bus.MEM_LDS, bus.REF_OVERRUN}), 32'b1_0000_1110);
    chk({tag, "_addr"}, 32'(bus.MEM_ADDR), 32'd0);
  endtask

  initial begin
    bit ref_seen;
    bus.CPU_AS = 1'b1; bus.CPU_CS = 1'b1; bus.CPU_RW = 1'b1;
    bus.CPU_UDS = 1'b1; bus.CPU_LDS = 1'b1; bus.CPU_ADDR = '0;
    bus.DMA_REQ = 1'b0; bus.DMA_RW = 1'b1; bus.DMA_BE = 2'b00; bus.DMA_ADDR = '0;
    bus.MEM_ACK = 1'b0; bus.MEM_REF_ACK = 1'b0;
    #12;
    chk_reset_outs("reset");

    // 1: single CPU read, ACK 4 cycles after MEM_REQ.
    do_reset();
    cpu_start(23'h012345, 1'b1, 1'b0, 1'b0);
    step(1);
    sb_check("cpu_rd");
    step(3);
    chk("cpu_rd_dtack_wait", 32'(bus.CPU_DTACK), 32'd1);
    mem_ack();
    chk("cpu_rd_req_drop", 32'(bus.MEM_REQ), 32'd0);
    chk("cpu_rd_dtack", 32'(bus.CPU_DTACK), 32'd0);
    step(2);
    chk("cpu_rd_dtack_hold", 32'(bus.CPU_DTACK), 32'd0);
    cpu_end();
    step(1);
    chk("cpu_rd_dtack_rel", 32'(bus.CPU_DTACK), 32'd1);
    step(3);
    chk("cpu_rd_no_regrant", 32'(bus.MEM_REQ), 32'd0);

    // 2: CPU and DMA together: CPU first, then DMA, then CPU again.
    do_reset();
    bus.DMA_REQ = 1'b1; bus.DMA_RW = 1'b1; bus.DMA_BE = 2'b01; bus.DMA_ADDR = 23'h00ABCD;
    cpu_start(23'h054321, 1'b0, 1'b0, 1'b1);
    step(1);
    sb_check("rr_cpu");
    chk("rr_cpu_gnt", 32'(bus.DMA_GNT), 32'd0);
    step(1);
    mem_ack();
    chk("rr_cpu_dtack", 32'(bus.CPU_DTACK), 32'd0);
    cpu_end();
    step(1);
    sb_q.push_back('{addr: 23'h00ABCD, rw: 1'b1, uds: 1'b1, lds: 1'b0});
    cpu_start(23'h011111, 1'b1, 1'b1, 1'b0);
    step(1);
    sb_check("rr_dma");
    chk("rr_dma_gnt", 32'(bus.DMA_GNT), 32'd1);
    step(1);
    mem_ack();
    chk("rr_dma_done", 32'({bus.DMA_DONE, bus.DMA_GNT, bus.MEM_REQ}), 32'b100);
    bus.DMA_REQ = 1'b0;
    step(1);
    chk("rr_dma_done_pulse", 32'(bus.DMA_DONE), 32'd0);
    sb_check("rr_cpu2");
    step(1);
    mem_ack();
    cpu_end();
    step(3);
    chk("rr_done_once", 32'(done_cnt), 32'd1);

    // 3a: idle refresh at the first tick.
    do_reset();
    step(150);
    chk("ref_idle_early", 32'(bus.MEM_REF_REQ), 32'd0);
    step(1);
    chk("ref_idle_req", 32'({bus.MEM_REF_REQ, bus.MEM_REQ}), 32'b10);
    step(3);
    ref_ack();
    chk("ref_idle_clr", 32'(bus.MEM_REF_REQ), 32'd0);
    step(140);
    chk("ref_idle_pend0", 32'(bus.MEM_REF_REQ), 32'd0);

    // 3b: back-to-back CPU cycles; refresh becomes urgent after two ticks.
    // Decisions fall on edges 1,5,9,...; the second tick lands on edge 300,
    // so refresh wins the decision on edge 301.
    do_reset();
    ref_seen = 1'b0;
    for (int i = 0; i < 100 && !ref_seen; i++) begin
      cpu_start(23'(i), 1'b1, 1'b0, 1'b0);
      step(1);
      if (bus.MEM_REF_REQ) begin
        ref_seen = 1'b1;
      end else begin
        sb_check("traffic");
        step(1);
        mem_ack();
        cpu_end();
        step(1);
      end
    end
    chk("urgent_seen", 32'(ref_seen), 32'd1);
    chk("urgent_edge", 32'(cyc), 32'd301);
    chk("urgent_no_mem", 32'(bus.MEM_REQ), 32'd0);
    step(2);
    ref_ack();
    step(1);
    sb_check("urgent_cpu_after");
    step(1);
    mem_ack();
    cpu_end();
    step(1);

    // 4: refresh ACK withheld. The first tick is granted at edge 151; ticks
    // at 300..1200 bring pending to 7; the tick at 1350 is lost.
    do_reset();
    step(1349);
    chk("sat_ref_held", 32'(bus.MEM_REF_REQ), 32'd1);
    chk("sat_no_ovr", 32'(bus.REF_OVERRUN), 32'd0);
    step(1);
    chk("sat_ovr", 32'(bus.REF_OVERRUN), 32'd1);
    ref_ack();
    step(5);
    chk("sat_ovr_sticky", 32'(bus.REF_OVERRUN), 32'd1);
    do_reset();
    chk("sat_ovr_rst", 32'(bus.REF_OVERRUN), 32'd0);

    // 5: reset in the middle of a DMA access.
    do_reset();
    bus.DMA_REQ = 1'b1; bus.DMA_RW = 1'b0; bus.DMA_BE = 2'b11; bus.DMA_ADDR = 23'h7FFFFF;
    sb_q.push_back('{addr: 23'h7FFFFF, rw: 1'b0, uds: 1'b0, lds: 1'b0});
    step(1);
    sb_check("rst_dma");
    chk("rst_dma_gnt", 32'(bus.DMA_GNT), 32'd1);
    step(1);
    #2 RST = 1'b1;
    #1 chk_reset_outs("rst_async");
    bus.DMA_REQ = 1'b0;
    bus.MEM_ACK = 1'b1;
    step(1);
    bus.MEM_ACK = 1'b0;
    do_reset();
    step(150);
    chk("rst_ref_early", 32'(bus.MEM_REF_REQ), 32'd0);
    step(1);
    chk("rst_ref_tick", 32'(bus.MEM_REF_REQ), 32'd1);
    chk("rst_no_done", 32'(done_cnt), 32'd0);

    // 6: CPU ends its cycle before MEM_ACK.
    do_reset();
    cpu_start(23'h000200, 1'b1, 1'b0, 1'b0);
    step(1);
    sb_check("abort");
    cpu_end();
    step(2);
    chk("abort_req_held", 32'(bus.MEM_REQ), 32'd1);
    mem_ack();
    chk("abort_ack", 32'({bus.MEM_REQ, bus.CPU_DTACK}), 32'b01);
    cpu_start(23'h000300, 1'b0, 1'b1, 1'b0);
    step(1);
    sb_check("abort_next_idle");
    step(1);
    mem_ack();
    cpu_end();
    step(2);
    chk("abort_dtack_rel", 32'(bus.CPU_DTACK), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Sits between the 68000 bus, a DMA requester and the DRAM controller.
- Decides which access the controller runs next: CPU read/write, DMA read/write, or a refresh cycle.
- Owns the refresh schedule, so the controller only executes the commands it is given.
- Presents 68000-style DTACK to the CPU and a level request / grant / done handshake to DMA.

Parameters:
REFRESH_INTERVAL, 150, CLK cycles between refresh ticks
MAX_PENDING, 2, pending-refresh count at which refresh becomes urgent (1..7)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset, asynchronous, active-high
CPU_AS  in  1  address strobe, active-low
CPU_CS  in  1  DRAM chip-select, active-low
CPU_RW  in  1  1=read, 0=write
CPU_UDS  in  1  upper data strobe, active-low
CPU_LDS  in  1  lower data strobe, active-low
CPU_ADDR  in  23  CPU address [23:1]
CPU_DTACK  out  1  DTACK to CPU, active-low
DMA_REQ  in  1  DMA request level, active-high
DMA_RW  in  1  1=read, 0=write
DMA_BE  in  2  byte enables [1]=upper, [0]=lower, active-high
DMA_ADDR  in  23  DMA address [23:1]
DMA_GNT  out  1  high while DMA access is in flight
DMA_DONE  out  1  one-cycle completion pulse
MEM_REQ  out  1  access request to controller, held until MEM_ACK
MEM_RW  out  1  registered direction
MEM_UDS  out  1  registered upper strobe, active-low
MEM_LDS  out  1  registered lower strobe, active-low
MEM_ADDR  out  23  registered address [23:1]
MEM_ACK  in  1  one-cycle pulse: access complete
MEM_REF_REQ  out  1  refresh request, held until MEM_REF_ACK
MEM_REF_ACK  in  1  one-cycle pulse: refresh complete
REF_OVERRUN  out  1  sticky flag: refresh tick lost at saturation

Behaviour:
- Reset values (RST high, asynchronous):
  - CPU_DTACK=1, DMA_GNT=0, DMA_DONE=0, MEM_REQ=0, MEM_REF_REQ=0, MEM_RW=1, MEM_UDS=1, MEM_LDS=1, MEM_ADDR=0, REF_OVERRUN=0.
  - Internal: tick counter=0, pending=0, state=IDLE, last-served=DMA.
  - Reset mid-operation abandons the access; no DONE or DTACK is issued.
- Refresh scheduler:
  - 8-bit tick counter counts 0..REFRESH_INTERVAL-1 and wraps. The wrap produces a tick.
  - A tick increments pending, which saturates at 7.
  - A tick arriving at 7 sets REF_OVERRUN.
  - A refresh grant decrements pending.
  - Tick and grant in the same cycle leave pending unchanged.
- Request terms, evaluated in IDLE only:
  - cpu_req = ~CPU_CS & ~CPU_AS.
  - dma_req = DMA_REQ.
  - urgent = pending>=MAX_PENDING.
- IDLE priority order:
  1. urgent refresh;
  2. CPU/DMA round-robin: if both request, grant the one not last served; else grant the sole requester;
  3. non-urgent refresh (pending>0), only when neither requests.
- States:
  - IDLE:
    - Grant decided at edge N.
    - At N+1: MEM_REQ=1 and MEM_ADDR/RW/UDS/LDS are registered from the winner. DMA strobes are ~DMA_BE.
    - On DMA grant, DMA_GNT=1.
    - Refresh grant sets MEM_REF_REQ=1.
    - Go to CPU_ACC, DMA_ACC or REF.
  - CPU_ACC:
    - Wait for MEM_ACK.
    - On ACK: MEM_REQ=0. If CPU_AS is still low, CPU_DTACK=0 and go to CPU_END; if CPU_AS is already high, go to IDLE with no DTACK.
  - CPU_END:
    - Hold CPU_DTACK=0 until CPU_AS is sampled high.
    - Then CPU_DTACK=1 and go to IDLE. This prevents the same bus cycle being re-granted.
  - DMA_ACC:
    - Wait for MEM_ACK.
    - On ACK: MEM_REQ=0, DMA_GNT=0, DMA_DONE=1 for one cycle, go to IDLE.
    - DMA_REQ must drop in the DONE cycle; if it is still high in IDLE, it is treated as a new request.
  - REF:
    - Wait for MEM_REF_ACK.
    - On ACK: MEM_REF_REQ=0, go to IDLE.
- Handshake and timing rules:
  - MEM_ACK outside CPU_ACC/DMA_ACC, or MEM_REF_ACK outside REF, is ignored.
  - MEM_* outputs are stable from request until ACK.
  - Latency: IDLE request to MEM_REQ is 1 cycle. MEM_ACK to DTACK/DONE is 1 cycle.
  - Minimum IDLE dwell between grants is 1 cycle.

Test Plan:
- Single CPU read (CS=0, AS=0, ADDR=0x012345, UDS=LDS=0); MEM_ACK 4 cycles after MEM_REQ -> MEM_REQ high 1 cycle after AS, MEM_ADDR=0x012345; CPU_DTACK low 1 cycle after ACK, high 1 cycle after AS rises; no second MEM_REQ.
- CPU and DMA request in the same cycle from reset -> CPU granted first. On the next IDLE with both still requesting, DMA is granted (DMA_GNT=1, MEM_UDS/LDS = ~DMA_BE, e.g. BE=2'b01 gives UDS=1, LDS=0), then DMA_DONE pulses once.
- Idle bus for 150 cycles -> MEM_REF_REQ rises; MEM_REF_ACK clears it and pending returns to 0. Continuous CPU traffic for 300 cycles -> pending reaches 2, and refresh wins the next IDLE over a waiting CPU.
- MEM_REF_ACK withheld for 8*150 cycles -> pending saturates at 7 and REF_OVERRUN=1, staying set after the ACK until RST.
- RST asserted mid DMA_ACC -> all outputs reach reset values without a clock edge; DMA_DONE never pulses; after RST falls, the first refresh tick is 150 cycles later.
- CPU_AS raised before MEM_ACK in CPU_ACC -> MEM_REQ held until ACK, CPU_DTACK stays 1, next cycle is IDLE.
